// File: rtl/mf8_pkg.sv
// Shared types and constants for the mf8 data-memory responder.
// Read data returned for timed-out and unmapped reads is fixed here.
package mf8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOC  = 2'd1,
    ST_EXT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] RD_TIMEOUT_DATA  = 8'hFF;
  localparam logic [7:0] RD_UNMAPPED_DATA = 8'h00;

endpackage

// File: rtl/mf8_spram.sv
// Single-port byte SRAM: synchronous read, write-first, contents not reset.
module mf8_spram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_o       <= wdata_i;
      end else begin
        rdata_o       <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/mf8_ram_responder.sv
// mf8 LD/ST responder: local SRAM window, external req/ack window, sticky error flag.
// ram_ready drops for the duration of each access and rises on the completion cycle.
module mf8_ram_responder
  import mf8_pkg::*;
#(
  parameter int          LOCAL_AW = 10,
  parameter logic [15:0] EXT_BASE = 16'h8000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] ZZ,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic [7:0]  ram_wdata,
  output logic [7:0]  ram_datain,
  output logic        ram_ready,
  output logic        ext_req,
  output logic        ext_we,
  output logic [14:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [1:0]  dbg_state_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [7:0]           datain_q, datain_d;
  logic                 ext_req_q, ext_req_d;
  logic                 we_q, we_d;
  logic [14:0]          ext_addr_q, ext_addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 loc_q, loc_d;
  logic [LOCAL_AW-1:0]  laddr_q, laddr_d;

  logic       strobe, hit_loc, hit_ext, err_set, rd_loc;
  logic [7:0] sram_rdata;

  assign strobe  = ram_read | ram_write;
  assign hit_loc = (ZZ >> LOCAL_AW) == 16'd0;
  assign hit_ext = ZZ >= EXT_BASE;
  assign rd_loc  = loc_q & ~we_q;

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    datain_d   = datain_q;
    ext_req_d  = ext_req_q;
    we_d       = we_q;
    ext_addr_d = ext_addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    loc_d      = loc_q;
    laddr_d    = laddr_q;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Local read data leaves the SRAM during DONE; hold it from here on.
        if (state_q == ST_DONE && rd_loc) datain_d = sram_rdata;
        state_d = ST_IDLE;
        if (strobe) begin
          we_d    = ram_write;
          wdata_d = ram_wdata;
          ready_d = 1'b0;
          cnt_d   = 8'd0;
          if (ram_read && ram_write) err_set = 1'b1;
          if (hit_ext) begin
            state_d    = ST_EXT;
            ext_req_d  = 1'b1;
            ext_addr_d = ZZ[14:0] - EXT_BASE[14:0];
            loc_d      = 1'b0;
          end else begin
            state_d = ST_LOC;
            loc_d   = hit_loc;
            laddr_d = ZZ[LOCAL_AW-1:0];
          end
        end
      end
      ST_LOC: begin
        if (strobe) err_set = 1'b1;
        state_d = ST_DONE;
        ready_d = 1'b1;
        if (!we_q && !loc_q) datain_d = RD_UNMAPPED_DATA;
      end
      ST_EXT: begin
        if (strobe) err_set = 1'b1;
        if (ext_ack) begin
          ext_req_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_DONE;
          if (!we_q) datain_d = ext_rdata;
        end else if (cnt_q == TO_LAST) begin
          ext_req_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_DONE;
          err_set   = 1'b1;
          if (!we_q) datain_d = RD_TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      datain_q   <= 8'h00;
      ext_req_q  <= 1'b0;
      we_q       <= 1'b0;
      ext_addr_q <= 15'd0;
      wdata_q    <= 8'h00;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
      loc_q      <= 1'b0;
      laddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      datain_q   <= datain_d;
      ext_req_q  <= ext_req_d;
      we_q       <= we_d;
      ext_addr_q <= ext_addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      loc_q      <= loc_d;
      laddr_q    <= laddr_d;
    end
  end

  mf8_spram #(.AW(LOCAL_AW)) u_spram (
    .clk_i   (Clk),
    .en_i    ((state_q == ST_LOC) && loc_q),
    .we_i    (we_q),
    .addr_i  (laddr_q),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

  assign ram_datain  = (state_q == ST_DONE && rd_loc) ? sram_rdata : datain_q;
  assign ram_ready   = ready_q;
  assign ext_req     = ext_req_q;
  assign ext_we      = we_q;
  assign ext_addr    = ext_addr_q;
  assign ext_wdata   = wdata_q;
  assign err_flag    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mf8_ram_responder.sv
// Directed bench for mf8_ram_responder: local, external, timeout, unmapped, hazard and reset cases.
// Valid/ready: a one-cycle ram_read/ram_write pulse starts an access; ram_ready high marks completion.
module tb_mf8_ram_responder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] ZZ;
  logic        ram_read, ram_write;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_datain;
  logic        ram_ready;
  logic        ext_req, ext_we;
  logic [14:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        ext_ack, err_clr, err_flag;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  mf8_ram_responder dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ZZ          (ZZ),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_wdata   (ram_wdata),
    .ram_datain  (ram_datain),
    .ram_ready   (ram_ready),
    .ext_req     (ext_req),
    .ext_we      (ext_we),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_rdata   (ext_rdata),
    .ext_ack     (ext_ack),
    .err_clr     (err_clr),
    .err_flag    (err_flag),
    .dbg_state_o (dbg_state)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle strobe; returns just after the accepting edge.
  task automatic strobe(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] wd);
    ZZ        = a;
    ram_read  = rd;
    ram_write = wr;
    ram_wdata = wd;
    tick();
    ram_read  = 1'b0;
    ram_write = 1'b0;
  endtask

  initial begin
    int n;
    Reset_n = 1'b0; ZZ = '0; ram_read = 0; ram_write = 0; ram_wdata = '0;
    ext_rdata = '0; ext_ack = 0; err_clr = 0;
    tick(); tick();
    chk("rst_ready", ram_ready, 1);
    chk("rst_datain", ram_datain, 8'h00);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_ext_we", ext_we, 0);
    chk("rst_ext_addr", ext_addr, 15'h0000);
    chk("rst_ext_wdata", ext_wdata, 8'h00);
    chk("rst_err", err_flag, 0);
    Reset_n = 1'b1;
    tick();

    // 1: local write then read
    strobe(16'h0012, 0, 1, 8'hA5);
    chk("t1_wr_busy", ram_ready, 0);
    tick();
    chk("t1_wr_done", ram_ready, 1);
    chk("t1_wr_datain_kept", ram_datain, 8'h00);
    strobe(16'h0012, 1, 0, 8'h00);
    chk("t1_rd_busy", ram_ready, 0);
    chk("t1_no_ext_req", ext_req, 0);
    tick();
    chk("t1_rd_done", ram_ready, 1);
    chk("t1_rd_data", ram_datain, 8'hA5);
    tick();
    chk("t1_rd_held", ram_datain, 8'hA5);

    // 2: external read, ack three cycles after ext_req
    strobe(16'h8034, 1, 0, 8'h00);
    chk("t2_req", ext_req, 1);
    chk("t2_addr", ext_addr, 15'h0034);
    chk("t2_we", ext_we, 0);
    chk("t2_busy", ram_ready, 0);
    tick(); tick();
    chk("t2_req_held", ext_req, 1);
    chk("t2_addr_stable", ext_addr, 15'h0034);
    chk("t2_busy_wait", ram_ready, 0);
    ext_ack = 1; ext_rdata = 8'h5C;
    tick();
    ext_ack = 0; ext_rdata = 8'h00;
    chk("t2_done", ram_ready, 1);
    chk("t2_req_drop", ext_req, 0);
    chk("t2_data", ram_datain, 8'h5C);
    // external write at top of window, ack in first EXT cycle
    strobe(16'hFFFF, 0, 1, 8'h9E);
    chk("t2w_addr", ext_addr, 15'h7FFF);
    chk("t2w_we", ext_we, 1);
    chk("t2w_wdata", ext_wdata, 8'h9E);
    ext_ack = 1; ext_rdata = 8'h33;
    tick();
    ext_ack = 0;
    chk("t2w_done", ram_ready, 1);
    chk("t2w_datain_kept", ram_datain, 8'h5C);
    tick();
    ext_ack = 1;
    tick();
    ext_ack = 0;
    chk("t2_idle_ack_ready", ram_ready, 1);
    chk("t2_idle_ack_data", ram_datain, 8'h5C);
    chk("t2_idle_ack_req", ext_req, 0);

    // 3: timeout
    strobe(16'h9000, 1, 0, 8'h00);
    chk("t3_addr", ext_addr, 15'h1000);
    n = 0;
    while (ext_req === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("t3_req_cycles", n, 255);
    chk("t3_ready", ram_ready, 1);
    chk("t3_data", ram_datain, 8'hFF);
    chk("t3_err", err_flag, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("t3_err_clr", err_flag, 0);

    // 4: unmapped accesses must not alias into the SRAM
    strobe(16'h0100, 0, 1, 8'h3C);
    tick();
    strobe(16'h0500, 0, 1, 8'h77);
    chk("t4_unm_wr_busy", ram_ready, 0);
    tick();
    chk("t4_unm_wr_done", ram_ready, 1);
    strobe(16'h0500, 1, 0, 8'h00);
    tick();
    chk("t4_unm_rd_ready", ram_ready, 1);
    chk("t4_unm_rd_data", ram_datain, 8'h00);
    strobe(16'h0100, 1, 0, 8'h00);
    tick();
    chk("t4_alias_intact", ram_datain, 8'h3C);
    strobe(16'h03FF, 0, 1, 8'hC3);
    tick();
    strobe(16'h03FF, 1, 0, 8'h00);
    tick();
    chk("t4_top_local", ram_datain, 8'hC3);
    strobe(16'h7FFF, 1, 0, 8'h00);
    chk("t4_top_unm_noreq", ext_req, 0);
    tick();
    chk("t4_top_unm_data", ram_datain, 8'h00);
    chk("t4_err", err_flag, 0);

    // 5: overrun during EXT, then read+write together with err_clr
    strobe(16'h8000, 1, 0, 8'h00);
    chk("t5_addr", ext_addr, 15'h0000);
    strobe(16'h0012, 0, 1, 8'h11);
    chk("t5_ovr_err", err_flag, 1);
    chk("t5_ovr_req", ext_req, 1);
    chk("t5_ovr_we", ext_we, 0);
    chk("t5_ovr_addr", ext_addr, 15'h0000);
    ext_ack = 1; ext_rdata = 8'hE7;
    tick();
    ext_ack = 0;
    chk("t5_ovr_done", ram_ready, 1);
    chk("t5_ovr_data", ram_datain, 8'hE7);
    err_clr = 1;
    tick();
    chk("t5_clr", err_flag, 0);
    ZZ = 16'h0012; ram_read = 1; ram_write = 1; ram_wdata = 8'h42;
    tick();
    ram_read = 0; ram_write = 0; err_clr = 0;
    chk("t5_rw_err_set_wins", err_flag, 1);
    chk("t5_rw_busy", ram_ready, 0);
    tick();
    chk("t5_rw_done", ram_ready, 1);
    chk("t5_rw_datain_kept", ram_datain, 8'hE7);
    strobe(16'h0012, 1, 0, 8'h00);
    tick();
    chk("t5_rw_was_write", ram_datain, 8'h42);

    // 6: reset in the middle of an external access
    strobe(16'h8100, 1, 0, 8'h00);
    chk("t6_req", ext_req, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_req_async", ext_req, 0);
    chk("t6_ready_async", ram_ready, 1);
    chk("t6_err_rst", err_flag, 0);
    tick();
    Reset_n = 1'b1;
    tick();
    strobe(16'h0012, 1, 0, 8'h00);
    chk("t6_post_busy", ram_ready, 0);
    tick();
    chk("t6_post_ready", ram_ready, 1);
    chk("t6_post_data", ram_datain, 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
